// File: rtl/cpu_pkg.sv
// Shared fetch-path types: machine width, reset vector, fetch FSM states and FIFO entry layout.
package cpu_pkg;

    localparam int              XLEN     = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_queue_fifo.sv
// sync_fifo: flop-based FIFO with flush, occupancy count and zeroed read data while empty.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Flush wins over a same-cycle push; the pushed word belongs to the discarded stream.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !do_pop)      count <= count + 1'b1;
            else if (!push && do_pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush && !rst) mem[wr_ptr] <= push_data;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst || flush) !(push && full && !do_pop));

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch front-end: credit-limited sequential fetch, in-order response FIFO, redirect flush.
// Optional IFETCH_MISALIGN_EN: misaligned redirects halt fetch and present a single fault entry.
module ifetch_queue
    import cpu_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
`ifdef IFETCH_MISALIGN_EN
    output logic            inst_fault,
`endif
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e    state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [XLEN-1:0] redir_pc;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   inflight_nxt;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_push;
    logic            fifo_pop;
    logic            req_fire;
    logic            credit_ok;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

    // Queued plus outstanding words never exceed DEPTH, so every response has a slot.
    assign credit_ok      = ({1'b0, fifo_count} + {1'b0, inflight}) < (CW+1)'(DEPTH);
    assign imem_req_valid = !rst && (state == ST_RUN) && !redirect_valid && credit_ok;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign inflight_nxt = inflight + CW'(req_fire) - CW'(imem_rsp_valid);

    assign fifo_push       = imem_rsp_valid && (drop == '0) && !redirect_valid;
    assign push_entry.pc   = rsp_pc;
    assign push_entry.data = imem_rsp_data;

    // A redirect condemns every word still in flight, including any arriving this cycle;
    // drop never exceeds inflight, so inflight_nxt already folds in any earlier drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
        end else begin
            inflight <= inflight_nxt;
            if (redirect_valid) begin
                fetch_pc <= redir_pc;
                rsp_pc   <= redir_pc;
                drop     <= inflight_nxt;
            end else begin
                if (req_fire)                        fetch_pc <= fetch_pc + 32'd4;
                if (fifo_push)                       rsp_pc   <= rsp_pc + 32'd4;
                if (imem_rsp_valid && drop != '0)    drop     <= drop - 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

`ifdef IFETCH_MISALIGN_EN
    logic            misalign;
    logic            fault_pend;
    logic [XLEN-1:0] fault_pc;

    assign misalign = |redirect_pc[1:0];
    assign redir_pc = redirect_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RUN;
            fault_pend <= 1'b0;
            fault_pc   <= '0;
        end else if (redirect_valid) begin
            state      <= misalign ? ST_FAULT : ST_RUN;
            fault_pend <= misalign;
            fault_pc   <= redirect_pc;
        end else if (fault_pend && inst_ready) begin
            fault_pend <= 1'b0;
        end
    end

    // The FIFO is empty whenever the fault entry is pending, so it simply overlays the head.
    assign inst_valid = fault_pend || !fifo_empty;
    assign inst_pc    = fault_pend ? fault_pc : head.pc;
    assign inst_data  = fault_pend ? '0 : head.data;
    assign inst_fault = fault_pend;
    assign fifo_pop   = inst_ready && !fault_pend;

    logic unused_ok;
    assign unused_ok = fifo_full;
`else
    assign state      = ST_RUN;
    assign redir_pc   = {redirect_pc[XLEN-1:2], 2'b00};
    assign inst_valid = !fifo_empty;
    assign inst_pc    = head.pc;
    assign inst_data  = head.data;
    assign fifo_pop   = inst_ready;

    logic unused_ok;
    assign unused_ok = &{1'b0, fifo_full, redirect_pc[1:0]};
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Random/directed bench for ifetch_queue against an epoch-tagged queue model with a fixed-latency memory.
module tb_ifetch_queue;
    import cpu_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid, inst_ready;
    logic [31:0] inst_data, inst_pc;
    logic        inst_fault;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
`ifdef IFETCH_MISALIGN_EN
        .inst_fault     (inst_fault),
`endif
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );
`ifndef IFETCH_MISALIGN_EN
    assign inst_fault = 1'b0;
`endif

    typedef struct {
        int          due;
        logic [31:0] addr;
        int          ep;
    } req_t;

    // Model: words queued for the CPU, requests pending in memory, fetch address, stream epoch.
    logic [63:0] mfifo[$];
    req_t        mq[$];
    logic [31:0] m_pc;
    int          epoch, cyc, lat, n_req;
    bit          m_halt, m_fpend;
    logic [31:0] m_fpc;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h13;
    endfunction

    task automatic do_reset(input int l);
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        @(posedge clk); @(negedge clk);
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst_pc", inst_pc, 0);
        chk("rst_inst_data", inst_data, 0);
        chk("rst_inst_fault", inst_fault, 0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        mfifo.delete(); mq.delete();
        m_pc = 32'h0; m_halt = 0; m_fpend = 0; m_fpc = '0;
        epoch++; lat = l; n_req = 0;
    endtask

    // One cycle: drive at the falling edge, check at +1, advance the model after the rising edge.
    task automatic step(input bit do_redir, input logic [31:0] rpc, input bit cpu_rdy, input bit mem_rdy);
        bit          rv, exp_req, exp_iv, acc;
        req_t        r;
        logic [63:0] hd;
        rv = (mq.size() > 0) && (mq[0].due == cyc);
        r  = rv ? mq[0] : '{0, 32'h0, 0};
        imem_rsp_valid = rv;
        imem_rsp_data  = rv ? mdata(r.addr) : 32'h0;
        redirect_valid = do_redir;
        redirect_pc    = rpc;
        inst_ready     = cpu_rdy;
        imem_req_ready = mem_rdy;
        #1;
        exp_req = !m_halt && !do_redir && (mfifo.size() + mq.size() < DEPTH);
        chk("req_valid", imem_req_valid, exp_req);
        if (exp_req && imem_req_valid) chk("req_addr", imem_req_addr, m_pc);
        exp_iv = m_fpend || (mfifo.size() > 0);
        chk("inst_valid", inst_valid, exp_iv);
        if (exp_iv) begin
            hd = m_fpend ? {m_fpc, 32'h0} : mfifo[0];
            chk("inst_pc", inst_pc, hd[63:32]);
            chk("inst_data", inst_data, hd[31:0]);
            chk("inst_fault", inst_fault, m_fpend);
        end
        acc = exp_req && mem_rdy;
        if (imem_req_valid && mem_rdy) n_req++;
        @(posedge clk);
        if (rv) void'(mq.pop_front());
        if (exp_iv && cpu_rdy) begin
            if (m_fpend) m_fpend = 0;
            else void'(mfifo.pop_front());
        end
        if (rv && r.ep == epoch && !do_redir) mfifo.push_back({r.addr, mdata(r.addr)});
        if (acc) begin
            mq.push_back('{cyc + lat, m_pc, epoch});
            m_pc = m_pc + 32'd4;
        end
        if (do_redir) begin
            mfifo.delete();
            epoch++;
`ifdef IFETCH_MISALIGN_EN
            m_halt  = (rpc[1:0] != 2'b00);
            m_fpend = m_halt;
            m_fpc   = rpc;
            m_pc    = rpc;
`else
            m_pc = {rpc[31:2], 2'b00};
`endif
        end
        cyc++;
        @(negedge clk);
    endtask

    bit          r_rd, r_cr, r_mr;
    logic [31:0] r_pc;

    initial begin
        epoch = 0; cyc = 0;

        // Stream at latency 1 with a always-ready CPU.
        do_reset(1);
        repeat (20) step(0, 0, 1, 1);

        // Backpressure: exactly DEPTH requests go out while the CPU stalls.
        do_reset(2);
        repeat (10) step(0, 0, 0, 1);
        chk("bp_req_count", n_req, DEPTH);
        repeat (10) step(0, 0, 1, 1);

        // Redirect with two requests outstanding at latency 3.
        do_reset(3);
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        step(1, 32'h100, 1, 1);
        repeat (12) step(0, 0, 1, 1);

        // Redirect coinciding with a response and a pop.
        do_reset(1);
        repeat (6) step(0, 0, 1, 1);
        step(1, 32'h40, 1, 1);
        repeat (8) step(0, 0, 1, 1);

        // Address wrap.
        step(1, 32'hFFFF_FFFC, 1, 1);
        repeat (8) step(0, 0, 1, 1);

        // Misaligned redirect, then an aligned one.
        step(1, 32'h102, 1, 1);
        repeat (4) step(0, 0, 0, 1);
        step(0, 0, 1, 1);
        repeat (2) step(0, 0, 1, 1);
        step(1, 32'h200, 1, 1);
        repeat (8) step(0, 0, 1, 1);

        // Randomized segments, each entered through a mid-stream reset.
        for (int seg = 0; seg < 4; seg++) begin
            do_reset(int'($urandom_range(1, 4)));
            for (int i = 0; i < 300; i++) begin
                r_rd = ($urandom_range(0, 99) < 6);
                r_cr = ($urandom_range(0, 99) < 70);
                r_mr = ($urandom_range(0, 99) < 80);
                r_pc = $urandom;
                case ($urandom_range(0, 3))
                    0:       r_pc = 32'hFFFF_FFF0 | (r_pc & 32'hC);
                    1:       r_pc = r_pc;
                    default: r_pc[1:0] = 2'b00;
                endcase
                step(r_rd, r_pc, r_cr, r_mr);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
